pico_io_bank: RTL and testbench
===============================

# pico_io_bank

Parametrised PicoBlaze I/O port peripheral that sits between the `pico_top` processor port bus and the RTC board logic. It provides:
- a bank of writable output registers;
- synchronised input channels with per-channel change detection;
- a read-to-clear status register and a mask register;
- a level interrupt with an acknowledge handshake.

It replaces the hand-decoded single in/out port with one address-mapped block that scales in width and channel count.

## Interface
- DATA_W, 8, port and register width in bits
- N_OUT, 4, number of output registers (1..16)
- N_IN, 4, number of input channels (1..DATA_W)
- BASE_ADDR, 8'h00, first port_id of the block; map must not cross 8'hFF
- SYNC_STAGES, 2, input synchroniser depth (≥2)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- port_id  input  8  processor port address
- write_strobe  input  1  one-cycle write qualifier
- read_strobe  input  1  one-cycle read qualifier
- out_port  input  DATA_W  write data from processor
- in_port  output  DATA_W  registered read data to processor
- ext_in  input  N_IN*DATA_W  asynchronous external inputs, channel i at [i*DATA_W +: DATA_W]
- ext_out  output  N_OUT*DATA_W  output registers, register j at [j*DATA_W +: DATA_W]
- interrupt  output  1  interrupt request to processor
- interrupt_ack  input  1  one-cycle acknowledge from processor

## Operation
- Address map, as offsets from BASE_ADDR:
  - 0..N_OUT-1: output registers, read/write.
  - N_OUT..N_OUT+N_IN-1: synchronised input values, read-only.
  - N_OUT+N_IN: STATUS, bit i is the change flag of channel i, read-to-clear.
  - N_OUT+N_IN+1: MASK, read/write, bit i enables channel i's interrupt.
  - Bits of STATUS/MASK at or above N_IN read 0 and ignore writes.
- Write: on the rising edge with write_strobe=1 and port_id decoding to an output register or MASK, that register loads out_port. Writes to input, STATUS or unmapped addresses are ignored.
- Input path: each channel passes through SYNC_STAGES flops, then one "previous" register. When the synced value differs from previous in any bit, the channel's STATUS bit is set.
- Read: in_port is registered every cycle from the decode of port_id. Unmapped addresses return 0. On the edge with read_strobe=1 and port_id=STATUS, all STATUS bits clear.
- Simultaneous clear and new change on the same channel: set wins, so the flag remains 1 and no event is lost.
- Interrupt: a pending event exists when any (STATUS & MASK) bit transitions 0→1. interrupt sets on the edge after a pending event and holds until interrupt_ack=1, then clears on that edge.
- Simultaneous ack and a new pending event: interrupt stays 1.
- A mask write that enables an already-set flag creates a pending event.
- Reset (asynchronous, any time, including mid-transaction): the following all go to 0 immediately:
  - ext_out, MASK, STATUS;
  - all sync and previous registers;
  - in_port, interrupt.

  A nonzero ext_in held across reset release therefore sets its STATUS flag SYNC_STAGES+1 cycles after release.

## Timing
- Write latency: ext_out updates on the same edge that samples write_strobe and is visible the following cycle.
- Read latency: in_port reflects port_id one cycle after port_id is stable. PicoBlaze holds port_id for 2 cycles, so data is valid when the processor samples it.
- The STATUS read returns the pre-clear value. The clear takes effect on the read_strobe edge.
- ext_in change to STATUS flag: SYNC_STAGES+1 cycles, i.e. 3 cycles at default.
- STATUS flag set to interrupt high: 1 cycle.
- interrupt_ack to interrupt low: 1 cycle.
- No combinational path from any input to any output.

## Test plan
All scenarios use default parameters, so the map is: outputs 0x00–0x03, inputs 0x04–0x07, STATUS 0x08, MASK 0x09.
- Reset then write 0x06 to port 0x02 → ext_out[23:16]=0x06 next cycle, other output bytes 0x00. Read 0x02 → in_port=0x06.
- ext_in channel 1 changes 0x00→0x76 → after 3 cycles, read 0x05 returns 0x76. Read 0x08 returns 0x02; a second read returns 0x00.
- MASK=0x01, channel 0 changes → interrupt=1 one cycle after the flag sets. It holds until the interrupt_ack pulse, then drops the next cycle.
- STATUS read issued on the same edge that channel 2's flag would set → read returns the old value and STATUS bit 2 remains 1 afterwards.
- Writes to 0x05 and 0x08 and a read of 0x0A → no register changes; in_port=0x00 for 0x0A.
- Assert rst_n=0 mid-write with interrupt high → all outputs 0 immediately. With ext_in=0x11 held, STATUS=0x01 three cycles after release.

Source files
------------

// File: rtl/pico_io_bank.sv
// Address-mapped PicoBlaze I/O bank: output registers, synchronised input channels
// with change flags, read-to-clear STATUS, MASK and a level interrupt with acknowledge.
module pico_io_bank #(
   parameter int          DATA_W      = 8,
   parameter int          N_OUT       = 4,
   parameter int          N_IN        = 4,
   parameter logic [7:0]  BASE_ADDR   = 8'h00,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                port_id,
   input  logic                      write_strobe,
   input  logic                      read_strobe,
   input  logic [DATA_W-1:0]         out_port,
   output logic [DATA_W-1:0]         in_port,
   input  logic [N_IN*DATA_W-1:0]    ext_in,
   output logic [N_OUT*DATA_W-1:0]   ext_out,
   output logic                      interrupt,
   input  logic                      interrupt_ack
);

   localparam logic [7:0] STATUS_OFF = 8'(N_OUT + N_IN);
   localparam logic [7:0] MASK_OFF   = 8'(N_OUT + N_IN + 1);

   logic [N_OUT*DATA_W-1:0] out_r;
   logic [N_IN*DATA_W-1:0]  sync_r [SYNC_STAGES];
   logic [N_IN*DATA_W-1:0]  prev_r;
   logic [N_IN-1:0]         status_r;
   logic [N_IN-1:0]         mask_r;
   logic [N_IN-1:0]         masked_prev_r;
   logic [DATA_W-1:0]       in_port_r;
   logic                    interrupt_r;

   logic [8:0]              diff_s;
   logic [7:0]              off_s;
   logic                    in_range_s;
   logic                    hit_status_s;
   logic                    hit_mask_s;
   logic                    status_clr_s;
   logic [N_IN-1:0]         change_s;
   logic [N_IN-1:0]         status_next_s;
   logic [N_IN-1:0]         masked_s;
   logic                    pending_s;
   logic                    interrupt_next_s;
   logic [DATA_W-1:0]       rd_data_s;

   // Address decode; the borrow bit of the 9-bit subtraction flags ports below the base.
   always_comb begin
      diff_s       = {1'b0, port_id} - {1'b0, BASE_ADDR};
      off_s        = diff_s[7:0];
      in_range_s   = ~diff_s[8];
      hit_status_s = in_range_s && (off_s == STATUS_OFF);
      hit_mask_s   = in_range_s && (off_s == MASK_OFF);
      status_clr_s = read_strobe && hit_status_s;
   end

   // Change detection, STATUS update (a new change beats a clear) and interrupt next state.
   always_comb begin
      change_s = '0;
      for (int i = 0; i < N_IN; i++) begin
         change_s[i] = (sync_r[SYNC_STAGES-1][i*DATA_W +: DATA_W] != prev_r[i*DATA_W +: DATA_W]);
      end
      if (status_clr_s) begin
         status_next_s = change_s;
      end else begin
         status_next_s = status_r | change_s;
      end
      masked_s  = status_r & mask_r;
      pending_s = |(masked_s & ~masked_prev_r);
      if (pending_s) begin
         interrupt_next_s = 1'b1;
      end else if (interrupt_ack) begin
         interrupt_next_s = 1'b0;
      end else begin
         interrupt_next_s = interrupt_r;
      end
   end

   // Read data mux as an OR of one-hot selected sources; unmapped ports yield zero.
   always_comb begin
      rd_data_s = '0;
      for (int j = 0; j < N_OUT; j++) begin
         rd_data_s = rd_data_s | ({DATA_W{in_range_s && (off_s == 8'(j))}}
                                  & out_r[j*DATA_W +: DATA_W]);
      end
      for (int i = 0; i < N_IN; i++) begin
         rd_data_s = rd_data_s | ({DATA_W{in_range_s && (off_s == 8'(N_OUT + i))}}
                                  & sync_r[SYNC_STAGES-1][i*DATA_W +: DATA_W]);
      end
      for (int i = 0; i < N_IN; i++) begin
         rd_data_s[i] = rd_data_s[i] | (hit_status_s & status_r[i]) | (hit_mask_s & mask_r[i]);
      end
   end

   // Processor-writable registers: output bank and MASK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r  <= '0;
         mask_r <= '0;
      end else begin
         for (int j = 0; j < N_OUT; j++) begin
            if (write_strobe && in_range_s && (off_s == 8'(j))) begin
               out_r[j*DATA_W +: DATA_W] <= out_port;
            end
         end
         if (write_strobe && hit_mask_s) begin
            mask_r <= out_port[N_IN-1:0];
         end
      end
   end

   // Input synchroniser chain and previous-value register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= '0;
         end
         prev_r <= '0;
      end else begin
         sync_r[0] <= ext_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
         end
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // STATUS flags, masked-flag history for edge detection, interrupt and read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_r      <= '0;
         masked_prev_r <= '0;
         interrupt_r   <= 1'b0;
         in_port_r     <= '0;
      end else begin
         status_r      <= status_next_s;
         masked_prev_r <= masked_s;
         interrupt_r   <= interrupt_next_s;
         in_port_r     <= rd_data_s;
      end
   end

   assign ext_out   = out_r;
   assign in_port   = in_port_r;
   assign interrupt = interrupt_r;

endmodule

// File: tb/tb_pico_io_bank.sv
// Directed bench for pico_io_bank at default parameters: register map vectors plus
// hand-written sequences for input latency, clear/set race, interrupt and reset.
module tb_pico_io_bank;

   logic        clk;
   logic        rst_n;
   logic [7:0]  port_id;
   logic        write_strobe;
   logic        read_strobe;
   logic [7:0]  out_port;
   logic [7:0]  in_port;
   logic [31:0] ext_in;
   logic [31:0] ext_out;
   logic        interrupt;
   logic        interrupt_ack;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic        do_wr;
      logic [7:0]  wr_addr;
      logic [7:0]  wr_data;
      logic [7:0]  rd_addr;
      logic [7:0]  exp_rd;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs [10];

   pico_io_bank dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .port_id       (port_id),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .out_port      (out_port),
      .in_port       (in_port),
      .ext_in        (ext_in),
      .ext_out       (ext_out),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      port_id      = addr;
      out_port     = data;
      write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data);
      @(negedge clk);
      port_id = addr;
      @(negedge clk);
      data = in_port;
   endtask

   task automatic rd_strobe(input logic [7:0] addr, output logic [7:0] data);
      @(negedge clk);
      port_id = addr;
      @(negedge clk);
      read_strobe = 1'b1;
      @(negedge clk);
      data        = in_port;
      read_strobe = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      pass_cnt      = 0;
      total_cnt     = 0;
      rst_n         = 1'b0;
      port_id       = 8'h00;
      write_strobe  = 1'b0;
      read_strobe   = 1'b0;
      out_port      = 8'h00;
      ext_in        = 32'h0000_0000;
      interrupt_ack = 1'b0;

      vecs[0] = '{1'b1, 8'h02, 8'h06, 8'h02, 8'h06, 32'h0006_0000};
      vecs[1] = '{1'b1, 8'h00, 8'hA5, 8'h00, 8'hA5, 32'h0006_00A5};
      vecs[2] = '{1'b1, 8'h03, 8'hFF, 8'h03, 8'hFF, 32'hFF06_00A5};
      vecs[3] = '{1'b1, 8'h01, 8'h3C, 8'h01, 8'h3C, 32'hFF06_3CA5};
      vecs[4] = '{1'b1, 8'h05, 8'h99, 8'h05, 8'h00, 32'hFF06_3CA5};
      vecs[5] = '{1'b1, 8'h08, 8'hFF, 8'h08, 8'h00, 32'hFF06_3CA5};
      vecs[6] = '{1'b1, 8'h09, 8'hF6, 8'h09, 8'h06, 32'hFF06_3CA5};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 32'hFF06_3CA5};
      vecs[8] = '{1'b1, 8'h0A, 8'h77, 8'h0A, 8'h00, 32'hFF06_3CA5};
      vecs[9] = '{1'b0, 8'h00, 8'h00, 8'h02, 8'h06, 32'hFF06_3CA5};

      repeat (2) @(negedge clk);
      chk("reset_in_port", {24'h0, in_port}, 32'h0);
      chk("reset_ext_out", ext_out, 32'h0);
      chk("reset_interrupt", {31'h0, interrupt}, 32'h0);
      rst_n = 1'b1;

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].do_wr) wr(vecs[v].wr_addr, vecs[v].wr_data);
         rd(vecs[v].rd_addr, d);
         chk($sformatf("vec%0d_in_port", v), {24'h0, d}, {24'h0, vecs[v].exp_rd});
         chk($sformatf("vec%0d_ext_out", v), ext_out, vecs[v].exp_out);
      end

      // Channel 1 change: latency to STATUS, synced value, read-to-clear.
      wr(8'h09, 8'h00);
      @(negedge clk);
      ext_in  = 32'h0000_7600;
      port_id = 8'h08;
      repeat (3) @(negedge clk);
      chk("ch1_status_not_yet", {24'h0, in_port}, 32'h0);
      @(negedge clk);
      chk("ch1_status_set", {24'h0, in_port}, 32'h02);
      rd(8'h05, d);
      chk("ch1_synced_value", {24'h0, d}, 32'h76);
      rd_strobe(8'h08, d);
      chk("status_read_first", {24'h0, d}, 32'h02);
      rd_strobe(8'h08, d);
      chk("status_read_second", {24'h0, d}, 32'h00);

      // Masked channel 0 change raises interrupt, held until ack.
      wr(8'h09, 8'h01);
      @(negedge clk);
      ext_in = 32'h0000_765A;
      repeat (3) @(negedge clk);
      chk("irq_low_at_flag", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      chk("irq_high", {31'h0, interrupt}, 32'h1);
      repeat (3) @(negedge clk);
      chk("irq_held", {31'h0, interrupt}, 32'h1);
      interrupt_ack = 1'b1;
      @(negedge clk);
      interrupt_ack = 1'b0;
      chk("irq_ack_clear", {31'h0, interrupt}, 32'h0);

      // Re-enabling the mask over a set flag creates a new pending event.
      wr(8'h09, 8'h00);
      wr(8'h09, 8'h01);
      chk("irq_mask_low", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      chk("irq_mask_enable", {31'h0, interrupt}, 32'h1);
      interrupt_ack = 1'b1;
      @(negedge clk);
      interrupt_ack = 1'b0;
      chk("irq_ack_clear2", {31'h0, interrupt}, 32'h0);
      rd_strobe(8'h08, d);
      chk("status_ch0_clear", {24'h0, d}, 32'h01);

      // STATUS read on the edge where channel 2's flag sets: set wins.
      @(negedge clk);
      ext_in  = 32'h0033_765A;
      port_id = 8'h08;
      repeat (2) @(negedge clk);
      read_strobe = 1'b1;
      @(negedge clk);
      read_strobe = 1'b0;
      chk("race_read_old", {24'h0, in_port}, 32'h00);
      @(negedge clk);
      chk("race_flag_kept", {24'h0, in_port}, 32'h04);
      rd_strobe(8'h08, d);
      chk("race_clear", {24'h0, d}, 32'h04);
      chk("race_no_irq", {31'h0, interrupt}, 32'h0);

      // Reset mid-write with interrupt high, then STATUS from held input after release.
      @(negedge clk);
      ext_in = 32'h0000_0011;
      repeat (5) @(negedge clk);
      chk("pre_reset_irq", {31'h0, interrupt}, 32'h1);
      port_id      = 8'h00;
      out_port     = 8'h12;
      write_strobe = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_ext_out", ext_out, 32'h0);
      chk("rst_in_port", {24'h0, in_port}, 32'h0);
      chk("rst_irq", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      chk("rst_hold_ext_out", ext_out, 32'h0);
      rst_n        = 1'b1;
      write_strobe = 1'b0;
      port_id      = 8'h08;
      repeat (3) @(negedge clk);
      chk("post_rst_status_early", {24'h0, in_port}, 32'h00);
      @(negedge clk);
      chk("post_rst_status", {24'h0, in_port}, 32'h01);
      chk("post_rst_no_irq", {31'h0, interrupt}, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
